// File: rtl/ht_task_queue.sv
// Elastic FIFO for hash-table tasks: DEPTH-entry RAM feeding a first-word-fall-through
// output register, with registered ready, fill level, almost-full and flush.
module ht_task_queue #(
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned CMD_WIDTH   = 2,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LVL   = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [KEY_WIDTH-1:0]     in_key_i,
  input  logic [VALUE_WIDTH-1:0]   in_value_i,
  input  logic [CMD_WIDTH-1:0]     in_cmd_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [KEY_WIDTH-1:0]     out_key_o,
  output logic [VALUE_WIDTH-1:0]   out_value_o,
  output logic [CMD_WIDTH-1:0]     out_cmd_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   used_o,
  output logic                     almost_full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = KEY_WIDTH + VALUE_WIDTH + CMD_WIDTH;
  localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullCnt = CntW'(AFULL_LVL);

  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] ram_cnt_q, ram_cnt_d;
  logic [CntW-1:0] used_q, used_d;
  logic [EntW-1:0] out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q;
  logic            afull_q;

  logic            push, pop, load_out, ram_empty, take_in, ram_wr, ram_rd;
  logic [EntW-1:0] in_entry;

  assign in_entry = {in_key_i, in_value_i, in_cmd_i};
  // Ready is held low for as long as reset is applied, registered otherwise.
  assign in_ready_o = in_ready_q & ~rst_i;
  assign push       = in_valid_i & in_ready_o;
  assign pop        = out_valid_q & out_ready_i;

  assign {out_key_o, out_value_o, out_cmd_o} = out_q;
  assign out_valid_o   = out_valid_q;
  assign used_o        = used_q;
  assign almost_full_o = afull_q;

  // Next-state: refill the output register from RAM first, else straight from the input.
  always_comb begin
    load_out    = ~out_valid_q | pop;
    ram_empty   = (ram_cnt_q == '0);
    take_in     = push & load_out & ram_empty;
    ram_wr      = push & ~take_in;
    ram_rd      = load_out & ~ram_empty;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (ram_rd) begin
      out_d       = mem_q[rptr_q];
      out_valid_d = 1'b1;
    end else if (take_in) begin
      out_d       = in_entry;
      out_valid_d = 1'b1;
    end else if (load_out) begin
      out_valid_d = 1'b0;
    end

    ram_cnt_d = ram_cnt_q;
    if (ram_wr && !ram_rd) begin
      ram_cnt_d = ram_cnt_q + CntW'(1);
    end else if (ram_rd && !ram_wr) begin
      ram_cnt_d = ram_cnt_q - CntW'(1);
    end

    used_d = used_q;
    if (push && !pop && used_q != FullCnt) begin
      used_d = used_q + CntW'(1);
    end else if (pop && !push && used_q != '0) begin
      used_d = used_q - CntW'(1);
    end
  end

  // Control state with reset over flush over normal operation.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ram_cnt_q   <= '0;
      used_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      afull_q     <= 1'b0;
    end else begin
      if (ram_wr) wptr_q <= wptr_q + PtrW'(1);
      if (ram_rd) rptr_q <= rptr_q + PtrW'(1);
      ram_cnt_q   <= ram_cnt_d;
      used_q      <= used_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (used_d != FullCnt);
      afull_q     <= (used_d >= AfullCnt);
    end
  end

  // Task storage; contents are don't-care after reset or flush.
  always_ff @(posedge clk_i) begin
    if (ram_wr) begin
      mem_q[wptr_q] <= in_entry;
    end
  end

`ifndef SYNTHESIS
  // Producer must hold a stalled task, unchanged, until it is accepted.
  a_valid_held : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (in_valid_i && !in_ready_o) |=> in_valid_i);
  a_data_stable : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (in_valid_i && !in_ready_o) |=> $stable(in_entry));
`endif

endmodule

// File: tb/tb_ht_task_queue.sv
// Scoreboard bench for ht_task_queue: directed tasks, expected entries queued at
// acceptance, an independent negedge monitor pops and compares every output transfer.
module tb_ht_task_queue;

  localparam logic [1:0] CmdSearch = 2'd0;
  localparam logic [1:0] CmdInsert = 2'd1;
  localparam logic [1:0] CmdDelete = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] in_key = '0;
  logic [15:0] in_value = '0;
  logic [1:0]  in_cmd = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_key;
  logic [15:0] out_value;
  logic [1:0]  out_cmd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  used;
  logic        afull;

  int n_tests = 0;
  int n_fail = 0;
  logic [49:0] exp_q[$];

  always #5 clk = ~clk;

  ht_task_queue #(
    .KEY_WIDTH(32), .VALUE_WIDTH(16), .CMD_WIDTH(2), .DEPTH(16), .AFULL_LVL(12)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_key_i(in_key), .in_value_i(in_value), .in_cmd_i(in_cmd),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_key_o(out_key), .out_value_o(out_value), .out_cmd_o(out_cmd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .used_o(used), .almost_full_o(afull)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one task and hold it until accepted; caller drops in_valid when done.
  task automatic push(input logic [31:0] k, input logic [15:0] v, input logic [1:0] c);
    in_key = k;
    in_value = v;
    in_cmd = c;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush && !rst) exp_q.push_back({k, v, c});
        tick();
        return;
      end
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL push_timeout: key %0h not accepted within 50 cycles", k);
  endtask

  // Monitor: every output transfer must match the oldest expected task.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none", {out_key, out_value, out_cmd});
      end else begin
        check("out_task", 64'({out_key, out_value, out_cmd}), 64'(exp_q.pop_front()));
      end
    end
    if (rst || flush) exp_q.delete();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset, then single task with latency of one edge.
    tick(); tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_used", 64'(used), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_afull", 64'(afull), 64'd0);
    check("rst_out_key", 64'(out_key), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    push(32'h0100_0000, 16'h1234, CmdSearch);
    in_valid = 1'b0;
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_used1", 64'(used), 64'd1);
    check("t1_out_key", 64'(out_key), 64'h0100_0000);
    tick();
    check("t1_used0", 64'(used), 64'd0);
    check("t1_out_valid_low", 64'(out_valid), 64'd0);

    // 2. Fill to 16 with output stalled, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(32'(i), 16'(i * 3), CmdInsert);
      check("t2_used", 64'(used), 64'(i + 1));
      check("t2_afull", 64'(afull), 64'((i + 1) >= 12));
      check("t2_in_ready", 64'(in_ready), 64'((i + 1) < 16));
    end
    in_valid = 1'b0;
    check("t2_out_key_held", 64'(out_key), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain_valid", 64'(out_valid), 64'd1);
      tick();
    end
    check("t2_drained_valid", 64'(out_valid), 64'd0);
    check("t2_drained_used", 64'(used), 64'd0);

    // 3. Full-rate push+pop with four entries resident.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hA000 + 32'(i), 16'(i), CmdDelete);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push(32'hB000 + 32'(i), 16'(i ^ 16'h5A5A), 2'(i % 3));
      check("t3_used_const", 64'(used), 64'd4);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t3_used_empty", 64'(used), 64'd0);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4. Full, single pop, ready returns one cycle later.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(32'hC000 + 32'(i), 16'(i), CmdInsert);
    in_valid = 1'b0;
    check("t4_full_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    check("t4_pop_cycle_ready", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b0;
    check("t4_ready_after_pop", 64'(in_ready), 64'd1);
    check("t4_used15", 64'(used), 64'd15);
    push(32'hC0FF_EE00, 16'hBEEF, CmdSearch);
    in_valid = 1'b0;
    check("t4_used16", 64'(used), 64'd16);
    check("t4_refull_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    check("t4_drained", 64'(used), 64'd0);

    // 5. Flush together with a push.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'hD000 + 32'(i), 16'(i), CmdInsert);
    check("t5_used8", 64'(used), 64'd8);
    in_key = 32'hDEAD_BEEF;
    in_value = 16'hFFFF;
    in_cmd = CmdDelete;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_used0", 64'(used), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_afull", 64'(afull), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("t5_no_output", 64'(out_valid), 64'd0);
    push(32'h0000_0055, 16'h0055, CmdSearch);
    in_valid = 1'b0;
    tick(); tick();
    check("t5_post_used", 64'(used), 64'd0);

    // 6. Reset in the middle of a burst.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'hE000 + 32'(i), 16'(i), CmdInsert);
    in_valid = 1'b0;
    check("t6_used5", 64'(used), 64'd5);
    rst = 1'b1;
    tick();
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_used0", 64'(used), 64'd0);
    check("t6_in_ready_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("t6_in_ready_post", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    push(32'hF000_0001, 16'h0101, CmdSearch);
    push(32'hF000_0002, 16'h0202, CmdDelete);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t6_used_end", 64'(used), 64'd0);
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
